rf_write_arbiter: RTL and testbench

- Shares the single register-file write port between two writeback sources.
- Source A is the in-order pipeline writeback, including LLB/LHB byte writes.
- Source B is the late/out-of-band writeback, e.g. a returning memory load after a miss.
- Registers the winning request and drives WriteReg/DstReg/DstData/llb/lhb of the register file one cycle later.
- Fixed A priority, with a starvation counter that forces a B grant.

---
 rtl/rf_arb_pkg.sv | 34 +++
 rtl/rf_arb_starve_ctr.sv | 61 ++++++
 rtl/rf_write_arbiter.sv | 144 ++++++++++++++
 tb/tb_rf_write_arbiter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rf_arb_pkg;

  // Arbitration state: normal A priority, or a one-cycle forced B grant.
  typedef enum logic {
    PRI_A   = 1'b0,
    FORCE_B = 1'b1
  } arb_state_e;

  // R0 is hard-wired zero in the register file.
  localparam logic [3:0] REG_ZERO = 4'h0;

  // Byte-select encodings driven towards the register file.
  localparam logic [1:0] BYTE_NONE = 2'b00;
  localparam logic [1:0] BYTE_LO   = 2'b01;
  localparam logic [1:0] BYTE_HI   = 2'b10;

  // Default number of consecutive refusals B tolerates before it is forced through.
  localparam int MAX_WAIT_DEF = 3;

  // Resolve the A byte-select pair. LLB wins over LHB, matching the register file.
  function automatic logic [1:0] byte_sel(input logic lo, input logic hi);
    if (lo) begin
      return BYTE_LO;
    end else if (hi) begin
      return BYTE_HI;
    end else begin
      return BYTE_NONE;
    end
  endfunction

endpackage

// File: rtl/rf_arb_starve_ctr.sv
// Counts consecutive B refusals and forces a single B grant once the limit is hit.
// Latency: force_b_o is registered; it rises the cycle after the limiting refusal.
// Backpressure: none of its own; it only steers the grant in the top level.
module rf_arb_starve_ctr
  import rf_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF  // legal range 1..15
) (
  input  logic clk,
  input  logic rst,
  input  logic refuse_i,   // B was valid and lost to A this cycle
  input  logic b_acc_i,    // B was accepted this cycle (incl. collision discard)
  output logic force_b_o
);

  localparam int CW = 4;
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

  arb_state_e     state_q, state_d;
  logic [CW-1:0]  wait_cnt_q, wait_cnt_d;

  // State and refusal counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= PRI_A;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next state: count refusals in PRI_A, spend exactly one cycle in FORCE_B.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      PRI_A: begin
        if (b_acc_i) begin
          wait_cnt_d = '0;
        end else if (refuse_i) begin
          wait_cnt_d = wait_cnt_q + 4'd1;
          if (wait_cnt_d == WAIT_LIMIT) begin
            state_d = FORCE_B;
          end
        end
      end
      FORCE_B: begin
        state_d    = PRI_A;
        wait_cnt_d = '0;
      end
      default: begin
        state_d    = PRI_A;
        wait_cnt_d = '0;
      end
    endcase
  end

  assign force_b_o = (state_q == FORCE_B);

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port between in-order writeback (A) and late writeback (B).
// Latency: an accepted request is written one cycle later, for exactly one cycle.
// Backpressure: A has fixed priority; B is forced through after MAX_WAIT refusals (optional bypass: RF_ARB_BYPASS_EN).
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int DW       = 16,
  parameter int RW       = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [RW-1:0] a_reg,
  input  logic [DW-1:0] a_data,
  input  logic          a_llb,
  input  logic          a_lhb,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [RW-1:0] b_reg,
  input  logic [DW-1:0] b_data,
  output logic          WriteReg,
  output logic [RW-1:0] DstReg,
  output logic [DW-1:0] DstData,
  output logic          llb,
  output logic          lhb,
  output logic          b_starved
`ifdef RF_ARB_BYPASS_EN
  ,
  input  logic [RW-1:0] byp_reg1,
  input  logic [RW-1:0] byp_reg2,
  input  logic [DW-1:0] byp_old1,
  input  logic [DW-1:0] byp_old2,
  output logic          byp_hit1,
  output logic          byp_hit2,
  output logic [DW-1:0] byp_data1,
  output logic [DW-1:0] byp_data2
`endif
);

  logic          force_b;
  logic          collide;
  logic          a_acc;
  logic          b_acc;
  logic          refuse;
  logic [1:0]    bsel;

  logic          wr_q, wr_d;
  logic [RW-1:0] dst_reg_q, dst_reg_d;
  logic [DW-1:0] dst_data_q, dst_data_d;
  logic          llb_q, llb_d;
  logic          lhb_q, lhb_d;

  // Same-register collision: A is newer, so B is taken off its queue and dropped.
  assign collide = a_valid & b_valid & (a_reg == b_reg);

  assign a_ready = a_valid & ~force_b;
  assign b_ready = force_b | (b_valid & (~a_valid | collide));

  assign a_acc  = a_ready;
  assign b_acc  = b_valid & b_ready;
  assign refuse = a_valid & b_valid & ~collide & ~force_b;

  rf_arb_starve_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk       (clk),
    .rst       (rst),
    .refuse_i  (refuse),
    .b_acc_i   (b_acc),
    .force_b_o (force_b)
  );

  // Grant mux: A wins whenever it is accepted (covers collisions); R0 writes are swallowed.
  always_comb begin
    wr_d       = 1'b0;
    dst_reg_d  = dst_reg_q;
    dst_data_d = dst_data_q;
    bsel       = BYTE_NONE;
    if (a_acc) begin
      dst_reg_d  = a_reg;
      dst_data_d = a_data;
      bsel       = byte_sel(a_llb, a_lhb);
      wr_d       = (a_reg != RW'(REG_ZERO));
    end else if (b_acc) begin
      dst_reg_d  = b_reg;
      dst_data_d = b_data;
      wr_d       = (b_reg != RW'(REG_ZERO));
    end
    llb_d = wr_d & (bsel == BYTE_LO);
    lhb_d = wr_d & (bsel == BYTE_HI);
  end

  // Output stage towards the register file; reset discards any pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q       <= 1'b0;
      dst_reg_q  <= '0;
      dst_data_q <= '0;
      llb_q      <= 1'b0;
      lhb_q      <= 1'b0;
    end else begin
      wr_q       <= wr_d;
      dst_reg_q  <= dst_reg_d;
      dst_data_q <= dst_data_d;
      llb_q      <= llb_d;
      lhb_q      <= lhb_d;
    end
  end

  assign WriteReg  = wr_q;
  assign DstReg    = dst_reg_q;
  assign DstData   = dst_data_q;
  assign llb       = llb_q;
  assign lhb       = lhb_q;
  assign b_starved = force_b;

`ifdef RF_ARB_BYPASS_EN
  // Byte-wise merge of the in-flight write over the current register contents.
  function automatic logic [DW-1:0] byp_merge(input logic [DW-1:0] old_v,
                                              input logic [DW-1:0] new_v,
                                              input logic          lo,
                                              input logic          hi);
    if (lo) begin
      return {old_v[DW-1:8], new_v[7:0]};
    end else if (hi) begin
      return {new_v[DW-1:8], old_v[7:0]};
    end else begin
      return new_v;
    end
  endfunction

  assign byp_hit1  = wr_q & (dst_reg_q == byp_reg1);
  assign byp_hit2  = wr_q & (dst_reg_q == byp_reg2);
  assign byp_data1 = byp_hit1 ? byp_merge(byp_old1, dst_data_q, llb_q, lhb_q) : byp_old1;
  assign byp_data2 = byp_hit2 ? byp_merge(byp_old2, dst_data_q, llb_q, lhb_q) : byp_old2;
`endif

  // Byte selects are mutually exclusive and only ever accompany a real write.
  a_byte_excl: assert property (@(posedge clk) disable iff (rst) !(llb && lhb));
  a_byte_wr:   assert property (@(posedge clk) disable iff (rst) (llb || lhb) |-> WriteReg);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench with a write scoreboard: stimulus queues expected writes, a monitor retires them.
// Latency: checks the one-cycle write delay and the starvation/collision/R0/reset corners.
// Backpressure: ready values are checked per vector against hand-computed expectations.
module tb_rf_write_arbiter;

  logic        clk;
  logic        rst;
  logic        a_valid;
  logic        a_ready;
  logic [3:0]  a_reg;
  logic [15:0] a_data;
  logic        a_llb;
  logic        a_lhb;
  logic        b_valid;
  logic        b_ready;
  logic [3:0]  b_reg;
  logic [15:0] b_data;
  logic        WriteReg;
  logic [3:0]  DstReg;
  logic [15:0] DstData;
  logic        llb;
  logic        lhb;
  logic        b_starved;

  typedef struct packed {
    logic [3:0]  r;
    logic [15:0] d;
    logic        l;
    logic        h;
  } wr_t;

  wr_t exp_q[$];
  int  vectors     = 0;
  int  miscompares = 0;

  rf_write_arbiter #(.MAX_WAIT(3), .DW(16), .RW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_reg     (a_reg),
    .a_data    (a_data),
    .a_llb     (a_llb),
    .a_lhb     (a_lhb),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_reg     (b_reg),
    .b_data    (b_data),
    .WriteReg  (WriteReg),
    .DstReg    (DstReg),
    .DstData   (DstData),
    .llb       (llb),
    .lhb       (lhb),
    .b_starved (b_starved)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: every write must match the oldest queued expectation; idle cycles carry no byte selects.
  always @(negedge clk) begin
    if (WriteReg === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got reg %0h data %0h expected no write at %0t",
                 DstReg, DstData, $time);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write", {10'd0, DstReg, DstData, llb, lhb}, {10'd0, e.r, e.d, e.l, e.h});
      end
    end else begin
      chk("idle_bytesel", {30'd0, llb, lhb}, 32'd0);
    end
  end

  // One cycle of stimulus: drive after the edge, queue the write it should cause, check readies mid-cycle.
  // ew: 0 = no write expected, 1 = A written, 2 = B written.
  task automatic step(input logic av, input logic [3:0] ar, input logic [15:0] ad,
                      input logic al, input logic ah,
                      input logic bv, input logic [3:0] br, input logic [15:0] bd,
                      input logic r, input logic ear, input logic ebr, input logic est,
                      input int ew);
    @(posedge clk);
    #1;
    rst = r; a_valid = av; a_reg = ar; a_data = ad; a_llb = al; a_lhb = ah;
    b_valid = bv; b_reg = br; b_data = bd;
    if (ew == 1) exp_q.push_back('{ar, ad, al, ah & ~al});
    if (ew == 2) exp_q.push_back('{br, bd, 1'b0, 1'b0});
    @(negedge clk);
    chk("a_ready",   {31'd0, a_ready},   {31'd0, ear});
    chk("b_ready",   {31'd0, b_ready},   {31'd0, ebr});
    chk("b_starved", {31'd0, b_starved}, {31'd0, est});
  endtask

  task automatic idle();
    step(0, 4'h0, 16'h0, 0, 0, 0, 4'h0, 16'h0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; a_valid = 0; a_reg = 0; a_data = 0; a_llb = 0; a_lhb = 0;
    b_valid = 0; b_reg = 0; b_data = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {9'd0, WriteReg, DstReg, DstData, llb, lhb, b_starved}, 32'd0);

    // A only, then idle
    step(1, 4'h3, 16'h1234, 0, 0, 0, 4'h0, 16'h0, 0, 1, 0, 0, 1);
    idle();
    // LLB, LHB, and the illegal both-set case (LLB wins)
    step(1, 4'h5, 16'h00AB, 1, 0, 0, 4'h0, 16'h0, 0, 1, 0, 0, 1);
    step(1, 4'h6, 16'hCD00, 0, 1, 0, 4'h0, 16'h0, 0, 1, 0, 0, 1);
    step(1, 4'h2, 16'h5566, 1, 1, 0, 4'h0, 16'h0, 0, 1, 0, 0, 1);
    // B only
    step(0, 4'h0, 16'h0, 0, 0, 1, 4'h4, 16'hBEEF, 0, 0, 1, 0, 2);
    // Starvation: three A wins, one forced B, then A resumes
    step(1, 4'h1, 16'hA001, 0, 0, 1, 4'h7, 16'h7777, 0, 1, 0, 0, 1);
    step(1, 4'h1, 16'hA002, 0, 0, 1, 4'h7, 16'h7777, 0, 1, 0, 0, 1);
    step(1, 4'h1, 16'hA003, 0, 0, 1, 4'h7, 16'h7777, 0, 1, 0, 0, 1);
    step(1, 4'h1, 16'hA004, 0, 0, 1, 4'h7, 16'h7777, 0, 0, 1, 1, 2);
    step(1, 4'h1, 16'hA004, 0, 0, 0, 4'h0, 16'h0,    0, 1, 0, 0, 1);
    // Collision after two refusals clears the wait count
    step(1, 4'h1, 16'hC001, 0, 0, 1, 4'h9, 16'h2222, 0, 1, 0, 0, 1);
    step(1, 4'h1, 16'hC002, 0, 0, 1, 4'h9, 16'h2222, 0, 1, 0, 0, 1);
    step(1, 4'h9, 16'h1111, 0, 0, 1, 4'h9, 16'h2222, 0, 1, 1, 0, 1);
    step(1, 4'h1, 16'hC003, 0, 0, 1, 4'h8, 16'h8888, 0, 1, 0, 0, 1);
    step(1, 4'h1, 16'hC004, 0, 0, 1, 4'h8, 16'h8888, 0, 1, 0, 0, 1);
    step(1, 4'h1, 16'hC005, 0, 0, 1, 4'h8, 16'h8888, 0, 1, 0, 0, 1);
    step(1, 4'h1, 16'hC006, 0, 0, 1, 4'h8, 16'h8888, 0, 0, 1, 1, 2);
    step(1, 4'h1, 16'hC006, 0, 0, 0, 4'h0, 16'h0,    0, 1, 0, 0, 1);
    idle();
    // R0 writes are accepted but never reach the register file
    step(0, 4'h0, 16'h0,    0, 0, 1, 4'h0, 16'hDEAD, 0, 0, 1, 0, 0);
    step(1, 4'h0, 16'h5555, 1, 0, 0, 4'h0, 16'h0,    0, 1, 0, 0, 0);
    idle();
    // Reset while a write is pending and the wait count is at 2
    step(1, 4'h1, 16'hD001, 0, 0, 1, 4'h7, 16'h7777, 0, 1, 0, 0, 1);
    step(1, 4'h1, 16'hD002, 0, 0, 1, 4'h7, 16'h7777, 0, 1, 0, 0, 1);
    step(1, 4'h1, 16'hD003, 0, 0, 1, 4'h7, 16'h7777, 1, 1, 0, 0, 0);
    step(1, 4'h1, 16'hD004, 0, 0, 1, 4'h7, 16'h7777, 0, 1, 0, 0, 1);
    chk("post_reset_outputs", {11'd0, WriteReg, DstReg, DstData}, 32'd0);
    step(1, 4'h1, 16'hD005, 0, 0, 1, 4'h7, 16'h7777, 0, 1, 0, 0, 1);
    step(1, 4'h1, 16'hD006, 0, 0, 1, 4'h7, 16'h7777, 0, 1, 0, 0, 1);
    step(1, 4'h1, 16'hD007, 0, 0, 1, 4'h7, 16'h7777, 0, 0, 1, 1, 2);
    step(1, 4'h1, 16'hD007, 0, 0, 0, 4'h0, 16'h0,    0, 1, 0, 0, 1);
    repeat (3) idle();

    @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

endmodule
